// File: rtl/matrix_datapath_pkg.sv
// Shared constants and types for the 4x4 matrix processor datapath.
// Opcode values, field widths and the packed matrix type live here.
package matrix_datapath_pkg;

  localparam int WIDTH_BIT = 2;
  localparam int INDEX_BIT = 3;
  localparam int INSTR_BIT = 8;
  localparam int WIDTH     = 1 << WIDTH_BIT;
  localparam int NREG      = 1 << INDEX_BIT;
  localparam int ELEM_BIT  = 32;
  localparam int CONST_BIT = 29 - 2 * INDEX_BIT;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_EMUL = 3'b010;
  localparam logic [2:0] OP_MMUL = 3'b011;
  localparam logic [2:0] OP_TRN  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_GEN  = 3'b110;
  localparam logic [2:0] OP_SYS  = 3'b111;

  // Element [row][col] of a matrix; row is the most significant index.
  typedef logic [WIDTH-1:0][WIDTH-1:0][ELEM_BIT-1:0] mat_t;

endpackage

// File: rtl/matrix_datapath_mat_alu.sv
// Combinational matrix ALU: element-wise add/sub/mul, matrix product,
// transpose, and pass-through of A for every other selector value.
module mat_alu
  import matrix_datapath_pkg::*;
(
  input  logic [2:0] sel,
  input  mat_t       a,
  input  mat_t       b,
  output mat_t       y
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_row
      for (gj = 0; gj < WIDTH; gj++) begin : g_col
        logic [ELEM_BIT-1:0] dot_next;
        logic [ELEM_BIT-1:0] elem_next;

        // Low 32 bits of a two's-complement sum of products match the signed result.
        always_comb begin
          dot_next = '0;
          for (int k = 0; k < WIDTH; k++) begin
            dot_next = dot_next + a[gi][k] * b[k][gj];
          end
        end

        always_comb begin
          case (sel)
            OP_ADD:  elem_next = a[gi][gj] + b[gi][gj];
            OP_SUB:  elem_next = a[gi][gj] - b[gi][gj];
            OP_EMUL: elem_next = a[gi][gj] * b[gi][gj];
            OP_MMUL: elem_next = dot_next;
            OP_TRN:  elem_next = a[gj][gi];
            default: elem_next = a[gi][gj];
          endcase
        end

        assign y[gi][gj] = elem_next;
      end
    end
  endgenerate

endmodule

// File: rtl/matrix_datapath.sv
// Decode, matrix register file and execute stage of the matrix processor.
// One instruction per cycle; write-back lands at the next rising clock edge.
module matrix_datapath
  import matrix_datapath_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic [31:0]          instruction,
  output logic                 PC_src,
  output logic [INSTR_BIT-1:0] jump_addr,
  output logic                 done,
  output mat_t                 result
);

  logic [2:0]           op;
  logic [INDEX_BIT-1:0] wr_idx;
  logic [INDEX_BIT-1:0] rd1_idx;
  logic [INDEX_BIT-1:0] rd2_idx;
  logic [CONST_BIT-1:0] const_field;
  logic                 write_enable;
  logic                 generated_enable;
  logic [ELEM_BIT-1:0]  gen_elem;
  mat_t                 gen_mat;
  mat_t                 rd_a;
  mat_t                 rd_b;
  mat_t                 alu_y;
  mat_t                 rf_q [NREG];

  assign op          = instruction[31:29];
  assign wr_idx      = instruction[28 -: INDEX_BIT];
  assign rd1_idx     = instruction[28-INDEX_BIT -: INDEX_BIT];
  assign const_field = instruction[CONST_BIT-1:0];
  assign rd2_idx     = const_field[CONST_BIT-1 -: INDEX_BIT];

  assign write_enable     = (op != OP_SYS);
  assign generated_enable = (op == OP_GEN);

  assign PC_src    = (op == OP_SYS) && !instruction[28];
  assign done      = (op == OP_SYS) &&  instruction[28];
  assign jump_addr = instruction[INSTR_BIT-1:0];

  assign gen_elem = {{(ELEM_BIT-CONST_BIT){const_field[CONST_BIT-1]}}, const_field};
  assign gen_mat  = {(WIDTH*WIDTH){gen_elem}};

  // Reads are combinational and unbypassed: a same-cycle write is seen next cycle.
  assign rd_a = rf_q[rd1_idx];
  assign rd_b = rf_q[rd2_idx];

  mat_alu u_alu (
    .sel (op),
    .a   (rd_a),
    .b   (rd_b),
    .y   (alu_y)
  );

  assign result = generated_enable ? gen_mat : alu_y;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      mat_t entry_reg;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          entry_reg <= '0;
        end else if (en && write_enable && (wr_idx == INDEX_BIT'(gi))) begin
          entry_reg <= result;
        end
      end

      assign rf_q[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: tb/tb_matrix_datapath.sv
// Randomized and directed bench for matrix_datapath against an array-based
// model of the eight matrix registers and the instruction semantics.
module tb_matrix_datapath;

  typedef logic [3:0][3:0][31:0] tmat_t;

  logic        CLK;
  logic        RST;
  logic        en;
  logic [31:0] instruction;
  logic        PC_src;
  logic [7:0]  jump_addr;
  logic        done;
  tmat_t       result;

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_txn    = 0;
  int    mdl [8][4][4];
  tmat_t obs_result;

  matrix_datapath dut (
    .CLK         (CLK),
    .RST         (RST),
    .en          (en),
    .instruction (instruction),
    .PC_src      (PC_src),
    .jump_addr   (jump_addr),
    .done        (done),
    .result      (result)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int wr, input int rd1, input logic [22:0] k);
    logic [2:0] o;
    logic [2:0] w;
    logic [2:0] r;
    o = 3'(op);
    w = 3'(wr);
    r = 3'(rd1);
    return {o, w, r, k};
  endfunction

  function automatic logic [31:0] enc_rr(input int op, input int wr, input int rd1, input int rd2);
    logic [2:0] r2;
    r2 = 3'(rd2);
    return enc(op, wr, rd1, {r2, 20'h0});
  endfunction

  // SYS/JUMP never writes, and its result shows reg[rd1]: a side-effect-free peek.
  function automatic logic [31:0] peek(input int r);
    return enc(7, 0, r, 23'h0);
  endfunction

  function automatic tmat_t model_eval(input logic [31:0] ins);
    tmat_t e;
    int op, r1, r2, k, acc;
    op = int'(ins[31:29]);
    r1 = int'(ins[25:23]);
    r2 = int'(ins[22:20]);
    k  = int'({{9{ins[22]}}, ins[22:0]});
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        case (op)
          0: e[i][j] = mdl[r1][i][j] + mdl[r2][i][j];
          1: e[i][j] = mdl[r1][i][j] - mdl[r2][i][j];
          2: e[i][j] = mdl[r1][i][j] * mdl[r2][i][j];
          3: begin
            acc = 0;
            for (int m = 0; m < 4; m++) acc += mdl[r1][i][m] * mdl[r2][m][j];
            e[i][j] = acc;
          end
          4: e[i][j] = mdl[r1][j][i];
          6: e[i][j] = k;
          default: e[i][j] = mdl[r1][i][j];
        endcase
      end
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mdl[r][i][j] = 0;
  endtask

  // Apply one instruction for a full cycle; outputs sampled at the falling edge.
  task automatic exec(input logic [31:0] ins, input logic e);
    tmat_t exp_res;
    logic  is_sys;
    instruction = ins;
    en          = e;
    @(negedge CLK);
    is_sys  = (ins[31:29] == 3'b111);
    exp_res = model_eval(ins);
    obs_result = result;
    n_txn++;
    $display("txn %0d ins=%h en=%b rst=%b pc_src=%b done=%b jump=%h", n_txn, ins, e, RST, PC_src, done, jump_addr);
    check("result", result, exp_res);
    check("pc_src", PC_src, is_sys && !ins[28]);
    check("done",   done,   is_sys && ins[28]);
    check("jump_addr", jump_addr, ins[7:0]);
    if (e && RST && !is_sys) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mdl[int'(ins[28:26])][i][j] = int'(exp_res[i][j]);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    en = 1'b0;
    instruction = 32'h0;
    model_clear();

    // Reset held low: registers read as zero through the peek path.
    @(posedge CLK); #1;
    exec(enc_rr(0, 1, 0, 0), 1'b1);
    check("write_during_reset", obs_result, '0);
    RST = 1'b1;
    exec(enc_rr(5, 1, 0, 0), 1'b1);
    check("mov_after_reset", obs_result, '0);
    for (int r = 0; r < 8; r++) exec(peek(r), 1'b1);

    // GEN then ADD.
    exec(enc(6, 1, 0, 23'd5), 1'b1);
    check("gen_5", obs_result, {16{32'd5}});
    exec(enc(6, 2, 0, 23'h7FFFFD), 1'b1);
    check("gen_m3", obs_result, {16{32'hFFFF_FFFD}});
    exec(enc_rr(0, 3, 1, 2), 1'b1);
    exec(peek(3), 1'b1);
    check("add_writeback", obs_result, {16{32'd2}});

    // MMUL / EMUL / SUB with all-2 and all-3.
    exec(enc(6, 1, 0, 23'd2), 1'b1);
    exec(enc(6, 2, 0, 23'd3), 1'b1);
    exec(enc_rr(3, 5, 1, 2), 1'b1);
    check("mmul_24", obs_result, {16{32'd24}});
    exec(enc_rr(2, 6, 1, 2), 1'b1);
    check("emul_6", obs_result, {16{32'd6}});
    exec(enc_rr(1, 7, 1, 2), 1'b1);
    check("sub_m1", obs_result, {16{32'hFFFF_FFFF}});

    // Self-overwrite: old value seen this cycle, new value next cycle.
    exec(enc_rr(0, 1, 1, 1), 1'b1);
    check("self_add_old", obs_result, {16{32'd4}});
    exec(peek(1), 1'b1);
    check("self_add_new", obs_result, {16{32'd4}});
    exec(enc(6, 4, 0, 23'd7), 1'b1);
    exec(enc_rr(4, 4, 4, 0), 1'b1);
    exec(enc_rr(0, 4, 4, 4), 1'b1);
    check("same_idx_old", obs_result, {16{32'd14}});

    // SYS: jump and halt, no writes.
    exec(enc(7, 0, 3, 23'h2A), 1'b1);
    check("jump_pc_src", PC_src, 1'b1);
    check("jump_42", jump_addr, 8'd42);
    exec(enc(7, 4, 3, 23'h11), 1'b1);
    check("halt_done", done, 1'b1);
    for (int r = 0; r < 8; r++) exec(peek(r), 1'b1);

    // en low gates the write.
    exec(enc_rr(0, 3, 1, 1), 1'b0);
    exec(peek(3), 1'b1);
    check("en_gate", obs_result, {16{32'd2}});

    // Asynchronous reset mid-cycle, checked before any clock edge.
    RST = 1'b0;
    model_clear();
    for (int r = 0; r < 8; r++) begin
      instruction = peek(r);
      #1;
      check("async_clear", result, '0);
    end
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Randomized program against the model.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:29] = 3'b110;
      exec(ins, ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 4) == 0) exec(peek($urandom_range(0, 7)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
